// File: rtl/cam_dvp_capture.sv
// rtl/cam_dvp_capture.sv - DVP camera capture into the shared RGB565 image BRAM
// Oversamples PCLK/VSYNC/HREF/D as data, pairs bytes into pixels, writes whole frames only.
module cam_dvp_capture #(
    parameter int width        = 200,
    parameter int height       = 164,
    parameter int addr_offset  = 1,
    parameter bit vsync_active = 1'b1
) (
    input  logic        CLK_24MHz,
    input  logic        rst_n,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        cam_wlock,
    output logic        img_wclk,
    output logic [15:0] img_wraddr,
    output logic [15:0] img_wrdat,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [15:0] width_w  = 16'(width);
    localparam logic [15:0] height_w = 16'(height);
    localparam logic [15:0] offset_w = 16'(addr_offset);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SKIP,
        S_CAPTURE
    } state_t;

    state_t state_q, state_d;

    // One synchronizer for all camera lines keeps them mutually aligned.
    // It is left unreset so a short reset does not fake a vsync edge.
    logic [10:0] sync1, sync2;
    logic        pclk_prev, href_prev;
    logic        s_vsync, s_href, s_pclk;

    logic        pe, pe_href;
    logic [7:0]  pe_data;

    logic [15:0] x_q, y_q, row_base_q;
    logic        phase_q, line_has_byte_q;
    logic [7:0]  hi_q;
    logic        wr_pending;

    logic        vs_active, href_rise, href_fall;
    logic        in_line_byte, pix_valid, pix_store;
    logic        capture_start, frame_done_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign s_pclk  = sync2[10];
    assign s_vsync = sync2[9];
    assign s_href  = sync2[8];

    always_ff @(posedge CLK_24MHz) begin
        sync1     <= {cam_pclk, cam_vsync, cam_href, cam_data};
        sync2     <= sync1;
        pclk_prev <= s_pclk;
        href_prev <= s_href;
    end

    always_ff @(posedge CLK_24MHz) begin
        if (!rst_n) begin
            pe      <= 1'b0;
            pe_href <= 1'b0;
            pe_data <= 8'd0;
        end else begin
            pe      <= s_pclk & ~pclk_prev;
            pe_href <= s_href;
            pe_data <= sync2[7:0];
        end
    end

    assign vs_active = (s_vsync == vsync_active);
    assign href_rise = s_href & ~href_prev;
    assign href_fall = ~s_href & href_prev;

    always_ff @(posedge CLK_24MHz) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        capture_start = 1'b0;
        frame_done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (vs_active) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                // The lock is honoured only here, so a frame is written whole or not at all.
                if (!vs_active) begin
                    if (cam_wlock) begin
                        state_d = S_SKIP;
                    end else begin
                        state_d       = S_CAPTURE;
                        capture_start = 1'b1;
                    end
                end
            end
            S_SKIP: begin
                if (vs_active) begin
                    state_d = S_BLANK;
                end
            end
            S_CAPTURE: begin
                if (vs_active) begin
                    state_d      = S_BLANK;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q == S_CAPTURE);
    assign in_line_byte = busy && pe && pe_href;
    assign pix_valid    = in_line_byte && phase_q;
    assign pix_store    = pix_valid && (x_q < width_w) && (y_q < height_w);

    always_ff @(posedge CLK_24MHz) begin
        if (!rst_n) begin
            x_q             <= 16'd0;
            y_q             <= 16'd0;
            row_base_q      <= 16'd0;
            phase_q         <= 1'b0;
            line_has_byte_q <= 1'b0;
            hi_q            <= 8'd0;
        end else if (capture_start) begin
            x_q             <= 16'd0;
            y_q             <= 16'd0;
            row_base_q      <= offset_w;
            phase_q         <= 1'b0;
            line_has_byte_q <= 1'b0;
        end else if (busy) begin
            if (href_rise) begin
                phase_q         <= 1'b0;
                line_has_byte_q <= 1'b0;
            end else if (href_fall) begin
                x_q             <= 16'd0;
                line_has_byte_q <= 1'b0;
                if (line_has_byte_q) begin
                    y_q        <= sat_inc(y_q);
                    row_base_q <= row_base_q + width_w;
                end
            end else if (in_line_byte) begin
                line_has_byte_q <= 1'b1;
                if (!phase_q) begin
                    hi_q    <= pe_data;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    x_q     <= sat_inc(x_q);
                end
            end
        end
    end

    // Address/data land one cycle after the pixel forms; the strobe follows a cycle later.
    always_ff @(posedge CLK_24MHz) begin
        if (!rst_n) begin
            wr_pending <= 1'b0;
            img_wclk   <= 1'b0;
            img_wraddr <= 16'd0;
            img_wrdat  <= 16'd0;
            frame_done <= 1'b0;
        end else begin
            wr_pending <= pix_store;
            img_wclk   <= wr_pending;
            frame_done <= frame_done_d;
            if (pix_store) begin
                img_wraddr <= row_base_q + x_q;
                img_wrdat  <= {hi_q, pe_data};
            end
        end
    end

endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb/tb_cam_dvp_capture.sv - self-checking bench for cam_dvp_capture
`timescale 1ns/1ps
module tb_cam_dvp_capture;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int OFF = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'd0;
    logic        cam_wlock = 1'b0;
    logic        img_wclk, frame_done, busy;
    logic [15:0] img_wraddr, img_wrdat;

    always #21 clk = ~clk;

    cam_dvp_capture #(
        .width(W), .height(H), .addr_offset(OFF), .vsync_active(1'b1)
    ) dut (
        .CLK_24MHz (clk),
        .rst_n     (rst_n),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .cam_wlock (cam_wlock),
        .img_wclk  (img_wclk),
        .img_wraddr(img_wraddr),
        .img_wrdat (img_wrdat),
        .frame_done(frame_done),
        .busy      (busy)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] got[$];
    int          done_cnt = 0;
    int          dbl_cnt = 0;
    logic        wclk_prev = 1'b0;

    always @(negedge clk) begin
        if (img_wclk) got.push_back({img_wraddr, img_wrdat});
        if (img_wclk && wclk_prev) dbl_cnt <= dbl_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        wclk_prev <= img_wclk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [7:0]  bytes[$];
    logic [31:0] exp_q[$];
    int          len[4];
    int          nlines;

    // Reference: pixel k of the n-th non-empty line goes to OFF + k + n*W when in range.
    task automatic build_expect(input logic lock0);
        int idx;
        int y;
        exp_q.delete();
        if (lock0) return;
        idx = 0;
        y = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int k = 0; k < len[l] / 2; k++) begin
                if (k < W && y < H)
                    exp_q.push_back({16'(OFF + k + y * W), bytes[idx + 2 * k], bytes[idx + 2 * k + 1]});
            end
            if (len[l] > 0) y++;
            idx += len[l];
        end
    endtask

    task automatic pclk_cycle(input logic href, input logic [7:0] d);
        cam_href = href;
        cam_data = d;
        #500 cam_pclk = 1'b1;
        #500 cam_pclk = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic lock0, input logic lock1, input logic rnd,
                             output int n_wr, output int n_done);
        int          gbase;
        int          dbase;
        logic        busy_seen;
        logic [7:0]  d;
        bytes.delete();
        cam_vsync = 1'b1;
        cam_wlock = lock0;
        repeat (4) pclk_cycle(1'b0, 8'd0);
        gbase = got.size();
        dbase = done_cnt;
        cam_vsync = 1'b0;
        pclk_cycle(1'b0, 8'd0);
        @(negedge clk);
        #1 busy_seen = busy;
        check({tag, " busy"}, busy_seen, !lock0);
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < len[l]; b++) begin
                d = rnd ? 8'($urandom) : 8'(bytes.size());
                bytes.push_back(d);
                pclk_cycle(1'b1, d);
            end
            pclk_cycle(1'b0, 8'd0);
            if (l == 0) cam_wlock = lock1;
        end
        cam_vsync = 1'b1;
        repeat (3) pclk_cycle(1'b0, 8'd0);
        @(negedge clk);
        #1;
        n_wr = got.size() - gbase;
        n_done = done_cnt - dbase;
        build_expect(lock0);
        check({tag, " model_count"}, n_wr, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n_wr; i++)
            check({tag, " write"}, got[gbase + i], exp_q[i]);
    endtask

    typedef struct {
        logic lock0;
        logic lock1;
        int   nl;
        int   l0, l1, l2;
        int   exp_wr;
        int   exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n_wr;
        int n_done;
        int gbase;
        int dbase;

        tbl[0] = '{1'b0, 1'b0, 2, 8, 8, 0, 8, 1};      // plain frame
        tbl[1] = '{1'b0, 1'b0, 3, 12, 12, 12, 8, 1};   // oversize lines and frame
        tbl[2] = '{1'b1, 1'b0, 2, 8, 8, 0, 0, 0};      // locked at start, released mid-frame
        tbl[3] = '{1'b0, 1'b0, 2, 8, 8, 0, 8, 1};      // released lock applies next frame
        tbl[4] = '{1'b0, 1'b1, 2, 8, 8, 0, 8, 1};      // lock mid-frame keeps frame
        tbl[5] = '{1'b1, 1'b1, 2, 8, 8, 0, 0, 0};      // following frame skipped
        tbl[6] = '{1'b0, 1'b0, 2, 5, 8, 0, 6, 1};      // odd trailing byte
        tbl[7] = '{1'b0, 1'b0, 2, 6, 2, 0, 4, 1};      // short lines

        repeat (10) @(negedge clk);
        #1;
        check("rst wclk", img_wclk, 0);
        check("rst addr", img_wraddr, 0);
        check("rst data", img_wrdat, 0);
        check("rst done", frame_done, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) begin
            nlines = tbl[t].nl;
            len[0] = tbl[t].l0;
            len[1] = tbl[t].l1;
            len[2] = tbl[t].l2;
            run_frame($sformatf("vec%0d", t), tbl[t].lock0, tbl[t].lock1, 1'b0, n_wr, n_done);
            check($sformatf("vec%0d strobes", t), n_wr, tbl[t].exp_wr);
            check($sformatf("vec%0d frame_done", t), n_done, tbl[t].exp_done);
        end

        // Reset in the middle of a frame after three pixels.
        gbase = got.size();
        cam_vsync = 1'b1;
        cam_wlock = 1'b0;
        repeat (4) pclk_cycle(1'b0, 8'd0);
        cam_vsync = 1'b0;
        pclk_cycle(1'b0, 8'd0);
        for (int b = 0; b < 6; b++) pclk_cycle(1'b1, 8'(8'hA0 + b));
        pclk_cycle(1'b0, 8'd0);
        check("pre-reset strobes", got.size() - gbase, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst wclk", img_wclk, 0);
        check("midrst addr", img_wraddr, 0);
        check("midrst data", img_wrdat, 0);
        check("midrst done", frame_done, 0);
        check("midrst busy", busy, 0);
        rst_n = 1'b1;
        gbase = got.size();
        dbase = done_cnt;
        for (int b = 0; b < 8; b++) pclk_cycle(1'b1, 8'(8'hB0 + b));
        pclk_cycle(1'b0, 8'd0);
        cam_vsync = 1'b1;
        repeat (3) pclk_cycle(1'b0, 8'd0);
        check("post-reset strobes", got.size() - gbase, 0);
        check("post-reset frame_done", done_cnt - dbase, 0);
        nlines = 2;
        len[0] = 8;
        len[1] = 8;
        run_frame("after_reset", 1'b0, 1'b0, 1'b0, n_wr, n_done);
        check("after_reset strobes", n_wr, 8);
        check("after_reset frame_done", n_done, 1);

        for (int r = 0; r < 6; r++) begin
            logic lk;
            lk = 1'($urandom_range(0, 3) == 0);
            nlines = $urandom_range(1, 3);
            for (int l = 0; l < 3; l++) len[l] = $urandom_range(1, 11);
            run_frame($sformatf("rnd%0d", r), lk, lk, 1'b1, n_wr, n_done);
            check($sformatf("rnd%0d frame_done", r), n_done, !lk);
        end

        check("single-cycle strobe", dbl_cnt, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
